// File: rtl/icb_dma_master.sv
// icb_dma_master: ICB bus master that moves LEN 32-bit words between memory and the datapath.
// Optional feature macro ICB_MST_ALIGN_CHK_EN: reject unaligned base addresses (done with err=1, no bus traffic).
module icb_dma_master #(
   parameter int MAX_OUTST = 4,
   parameter int LEN_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_read,
   input  logic [31:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [31:0]      wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [31:0]      rd_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             icb_cmd_valid,
   input  logic             icb_cmd_ready,
   output logic             icb_cmd_read,
   output logic [31:0]      icb_cmd_addr,
   output logic [31:0]      icb_cmd_wdata,
   output logic [3:0]       icb_cmd_wmask,
   input  logic             icb_rsp_valid,
   output logic             icb_rsp_ready,
   input  logic [31:0]      icb_rsp_rdata,
   input  logic             icb_rsp_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t           state, state_nxt;
   logic [31:0]      base;
   logic [LEN_W-1:0] len, cmd_cnt;
   logic [3:0]       outst, outst_nxt;
   logic             rd_job, err_q, accept, active, elig, cmd_hs, rsp_hs, last_cmd, addr_bad;

`ifdef ICB_MST_ALIGN_CHK_EN
   assign addr_bad = req_addr[1:0] != 2'b00;
`else
   assign addr_bad = 1'b0;
`endif
   assign accept    = req_valid && state == IDLE;
   assign active    = state == ISSUE || state == DRAIN;
   assign elig      = state == ISSUE && outst < 4'(MAX_OUTST) && (rd_job || wr_valid);
   assign cmd_hs    = elig && icb_cmd_ready;
   assign rsp_hs    = active && icb_rsp_valid && icb_rsp_ready;
   assign last_cmd  = cmd_hs && cmd_cnt == len - LEN_W'(1);
   assign outst_nxt = outst + {3'b000, cmd_hs} - {3'b000, rsp_hs};

   // State register; async reset aborts any job without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Job context, command counter, in-flight counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base    <= '0;
         len     <= '0;
         rd_job  <= 1'b0;
         cmd_cnt <= '0;
         outst   <= '0;
         err_q   <= 1'b0;
      end else begin
         outst <= outst_nxt;
         if (accept) begin
            base    <= req_addr & ~32'h3;
            len     <= req_len;
            rd_job  <= req_read;
            cmd_cnt <= '0;
            err_q   <= addr_bad;
         end else begin
            if (cmd_hs) cmd_cnt <= cmd_cnt + LEN_W'(1);
            if (rsp_hs && icb_rsp_err) err_q <= 1'b1;
         end
      end
   end

   // Next state plus all bus/stream outputs; responses pass straight through for reads
   always_comb begin
      state_nxt     = state;
      req_ready     = state == IDLE;
      busy          = state != IDLE;
      done          = state == DONE;
      err           = err_q;
      icb_cmd_valid = elig;
      icb_cmd_read  = rd_job;
      icb_cmd_addr  = base + (32'(cmd_cnt) << 2);
      icb_cmd_wdata = (elig && !rd_job) ? wr_data : 32'h0;
      icb_cmd_wmask = 4'hF;
      wr_ready      = icb_cmd_ready && elig && !rd_job;
      rd_valid      = active && rd_job && icb_rsp_valid;
      rd_data       = rd_valid ? icb_rsp_rdata : 32'h0;
      icb_rsp_ready = state == IDLE ? icb_rsp_valid : (rd_job ? rd_ready : 1'b1);
      case (state)
         IDLE:    if (accept) state_nxt = (req_len == '0 || addr_bad) ? DONE : ISSUE;
         ISSUE:   if (last_cmd) state_nxt = outst_nxt == 4'd0 ? DONE : DRAIN;
         DRAIN:   if (outst_nxt == 4'd0) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_icb_dma_master.sv
// tb_icb_dma_master: scoreboard bench for icb_dma_master with an in-order ICB slave model.
module tb_icb_dma_master;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic        req_valid, req_ready, req_read;
   logic [31:0] req_addr;
   logic [15:0] req_len;
   logic        wr_valid, wr_ready, rd_valid, rd_ready;
   logic [31:0] wr_data, rd_data;
   logic        busy, done, err;
   logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [31:0] icb_cmd_addr, icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [31:0] icb_rsp_rdata;

   int checks = 0, passed = 0;
   int cyc = 0, cmd_idx, err_at, last_rsp_cyc, done_cyc, done_cnt, max_pend, bp_bad, wr_beats;
   bit rdy_rand, hold_rsp, wr_gap, rd_bp;
   logic [31:0] pend_data[$], wr_q[$], obs_addr[$], obs_wdata[$], obs_rd[$];
   logic [31:0] exp_addr[$], exp_rd[$], exp_wd[$];
   logic [3:0]  obs_mask[$];
   logic        obs_read[$];
   bit          pend_err[$];

   icb_dma_master #(.MAX_OUTST(4), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
      .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1);
   end

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic clear();
      pend_data.delete(); pend_err.delete(); wr_q.delete();
      obs_addr.delete(); obs_wdata.delete(); obs_rd.delete(); obs_mask.delete(); obs_read.delete();
      exp_addr.delete(); exp_rd.delete(); exp_wd.delete();
      rdy_rand = 0; hold_rsp = 0; wr_gap = 0; rd_bp = 0;
      err_at = -1; cmd_idx = 0; last_rsp_cyc = -1; done_cyc = -1;
      done_cnt = 0; max_pend = 0; bp_bad = 0; wr_beats = 0;
   endtask

   // One clock of slave/source/sink behaviour; observations land in the obs_* queues
   task automatic step();
      @(negedge clk);
      cyc++;
      icb_cmd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      icb_rsp_valid = !hold_rsp && pend_data.size() > 0;
      icb_rsp_rdata = icb_rsp_valid ? pend_data[0] : 32'h0;
      icb_rsp_err   = icb_rsp_valid ? pend_err[0] : 1'b0;
      wr_valid      = wr_q.size() > 0 && (!wr_gap || $urandom_range(0, 1) == 1);
      wr_data       = wr_q.size() > 0 ? wr_q[0] : 32'h0;
      rd_ready      = rd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (busy && icb_cmd_read && icb_rsp_valid && !rd_ready && icb_rsp_ready) bp_bad++;
      if (icb_rsp_valid && icb_rsp_ready) begin
         if (rd_valid) obs_rd.push_back(rd_data);
         void'(pend_data.pop_front());
         void'(pend_err.pop_front());
         last_rsp_cyc = cyc;
      end
      if (icb_cmd_valid && icb_cmd_ready) begin
         obs_addr.push_back(icb_cmd_addr);
         obs_wdata.push_back(icb_cmd_wdata);
         obs_mask.push_back(icb_cmd_wmask);
         obs_read.push_back(icb_cmd_read);
         pend_data.push_back(icb_cmd_read ? mem(icb_cmd_addr) : 32'h0);
         pend_err.push_back(cmd_idx == err_at);
         cmd_idx++;
      end
      if (wr_valid && wr_ready) begin
         void'(wr_q.pop_front());
         wr_beats++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (pend_data.size() > max_pend) max_pend = pend_data.size();
   endtask

   task automatic start_job(input logic rd, input logic [31:0] a, input logic [15:0] n);
      @(negedge clk);
      req_valid = 1'b1; req_read = rd; req_addr = a; req_len = n;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic run_until_done(input int budget, output bit ok);
      int s = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && s < budget) begin
         step();
         s++;
      end
      ok = done_cnt != d0;
   endtask

   task automatic test_reset();
      req_valid = 0; req_read = 0; req_addr = 0; req_len = 0;
      wr_valid = 0; wr_data = 0; rd_ready = 0;
      icb_cmd_ready = 0; icb_rsp_valid = 0; icb_rsp_rdata = 0; icb_rsp_err = 0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, busy, done, err, icb_cmd_valid, icb_cmd_read, icb_rsp_ready, rd_valid, wr_ready} !== 9'b1_0000_0000)
         $display("FAIL reset_ctrl got %b exp %b",
                  {req_ready, busy, done, err, icb_cmd_valid, icb_cmd_read, icb_rsp_ready, rd_valid, wr_ready}, 9'b1_0000_0000);
      else passed++;
      checks++;
      if ({icb_cmd_wmask, icb_cmd_addr, icb_cmd_wdata, rd_data} !== {4'hF, 96'h0})
         $display("FAIL reset_data got mask=%h addr=%h wdata=%h rdata=%h exp F/0/0/0",
                  icb_cmd_wmask, icb_cmd_addr, icb_cmd_wdata, rd_data);
      else passed++;
      clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      bit ok;
      logic [31:0] a;
      clear();
      for (int i = 0; i < 4; i++) begin
         exp_addr.push_back(32'h1000 + 32'(4 * i));
         exp_rd.push_back(mem(32'h1000 + 32'(4 * i)));
      end
      start_job(1'b1, 32'h1000, 16'd4);
      step();
      checks++;
      if (icb_cmd_valid !== 1'b1) $display("FAIL read_latency cmd_valid got %b exp 1", icb_cmd_valid);
      else passed++;
      run_until_done(50, ok);
      checks++;
      if (ok !== 1'b1) $display("FAIL read_done_timeout got %b exp 1", ok);
      else passed++;
      checks++;
      if (obs_addr.size() !== 4) $display("FAIL read_cmd_count got %0d exp 4", obs_addr.size());
      else passed++;
      while (exp_addr.size() > 0) begin
         a = obs_addr.size() > 0 ? obs_addr.pop_front() : 32'hx;
         checks++;
         if (a !== exp_addr[0]) $display("FAIL read_addr got %h exp %h", a, exp_addr[0]);
         else passed++;
         void'(exp_addr.pop_front());
      end
      while (exp_rd.size() > 0) begin
         a = obs_rd.size() > 0 ? obs_rd.pop_front() : 32'hx;
         checks++;
         if (a !== exp_rd[0]) $display("FAIL read_data got %h exp %h", a, exp_rd[0]);
         else passed++;
         void'(exp_rd.pop_front());
      end
      checks++;
      if (done_cyc !== last_rsp_cyc + 1) $display("FAIL read_done_timing got cyc %0d exp %0d", done_cyc, last_rsp_cyc + 1);
      else passed++;
      checks++;
      if (err !== 1'b0) $display("FAIL read_err got %b exp 0", err);
      else passed++;
      step(); step();
      checks++;
      if (done_cnt !== 1 || req_ready !== 1'b1) $display("FAIL read_done_once got cnt=%0d ready=%b exp 1/1", done_cnt, req_ready);
      else passed++;
   endtask

   task automatic test_write();
      bit ok;
      logic [31:0] w;
      clear();
      rdy_rand = 1; wr_gap = 1;
      for (int i = 0; i < 3; i++) begin
         w = 32'hC0DE_0000 + 32'($urandom_range(0, 16'hFFFF));
         wr_q.push_back(w);
         exp_wd.push_back(w);
         exp_addr.push_back(32'h2000 + 32'(4 * i));
      end
      start_job(1'b0, 32'h2000, 16'd3);
      run_until_done(300, ok);
      checks++;
      if (ok !== 1'b1) $display("FAIL write_done_timeout got %b exp 1", ok);
      else passed++;
      checks++;
      if (obs_addr.size() !== 3 || wr_beats !== 3) $display("FAIL write_counts got cmds=%0d beats=%0d exp 3/3", obs_addr.size(), wr_beats);
      else passed++;
      while (exp_wd.size() > 0) begin
         checks++;
         if (obs_wdata.size() == 0) $display("FAIL write_missing got none exp wdata %h", exp_wd[0]);
         else if ({obs_addr[0], obs_wdata[0], obs_mask[0], obs_read[0]} !== {exp_addr[0], exp_wd[0], 4'hF, 1'b0})
            $display("FAIL write_cmd got addr=%h wdata=%h mask=%h rd=%b exp %h/%h/F/0",
                     obs_addr[0], obs_wdata[0], obs_mask[0], obs_read[0], exp_addr[0], exp_wd[0]);
         else passed++;
         if (obs_wdata.size() > 0) begin
            void'(obs_addr.pop_front()); void'(obs_wdata.pop_front());
            void'(obs_mask.pop_front()); void'(obs_read.pop_front());
         end
         void'(exp_wd.pop_front()); void'(exp_addr.pop_front());
      end
   endtask

   task automatic test_outstanding();
      bit ok;
      logic [31:0] a;
      clear();
      hold_rsp = 1;
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(32'h3000 + 32'(4 * i));
         exp_rd.push_back(mem(32'h3000 + 32'(4 * i)));
      end
      start_job(1'b1, 32'h3000, 16'd8);
      repeat (10) step();
      checks++;
      if (obs_addr.size() !== 4 || icb_cmd_valid !== 1'b0)
         $display("FAIL outst_stall got cmds=%0d cmd_valid=%b exp 4/0", obs_addr.size(), icb_cmd_valid);
      else passed++;
      hold_rsp = 0;
      step(); step();
      checks++;
      if (obs_addr.size() !== 5) $display("FAIL outst_resume got cmds=%0d exp 5", obs_addr.size());
      else passed++;
      run_until_done(100, ok);
      checks++;
      if (ok !== 1'b1 || max_pend !== 4) $display("FAIL outst_done got ok=%b max_pend=%0d exp 1/4", ok, max_pend);
      else passed++;
      while (exp_addr.size() > 0) begin
         a = obs_addr.size() > 0 ? obs_addr.pop_front() : 32'hx;
         checks++;
         if (a !== exp_addr[0]) $display("FAIL outst_addr got %h exp %h", a, exp_addr[0]);
         else passed++;
         void'(exp_addr.pop_front());
      end
      while (exp_rd.size() > 0) begin
         a = obs_rd.size() > 0 ? obs_rd.pop_front() : 32'hx;
         checks++;
         if (a !== exp_rd[0]) $display("FAIL outst_data got %h exp %h", a, exp_rd[0]);
         else passed++;
         void'(exp_rd.pop_front());
      end
   endtask

   task automatic test_len0_wrap();
      bit ok;
      clear();
      start_job(1'b1, 32'h4000, 16'd0);
      step();
      checks++;
      if (done !== 1'b1 || obs_addr.size() !== 0) $display("FAIL len0_done got done=%b cmds=%0d exp 1/0", done, obs_addr.size());
      else passed++;
      step();
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1 || obs_addr.size() !== 0)
         $display("FAIL len0_idle got done=%b ready=%b cmds=%0d exp 0/1/0", done, req_ready, obs_addr.size());
      else passed++;
      clear();
      exp_addr.push_back(32'hFFFF_FFFC);
      exp_addr.push_back(32'h0000_0000);
      start_job(1'b1, 32'hFFFF_FFFC, 16'd2);
      run_until_done(50, ok);
      checks++;
      if (ok !== 1'b1 || obs_addr.size() !== 2) $display("FAIL wrap_count got ok=%b cmds=%0d exp 1/2", ok, obs_addr.size());
      else passed++;
      checks++;
      if (obs_addr.size() == 2 && obs_addr[1] !== exp_addr[1]) $display("FAIL wrap_addr got %h exp %h", obs_addr[1], exp_addr[1]);
      else if (obs_addr.size() != 2) $display("FAIL wrap_addr got %0d cmds exp 2", obs_addr.size());
      else passed++;
      checks++;
      if (obs_rd.size() != 2 || obs_rd[1] !== mem(exp_addr[1])) $display("FAIL wrap_data got %0d words exp 2 with %h", obs_rd.size(), mem(exp_addr[1]));
      else passed++;
   endtask

   task automatic test_err();
      bit ok;
      logic [31:0] a;
      clear();
      err_at = 1; rd_bp = 1;
      for (int i = 0; i < 4; i++) exp_rd.push_back(mem(32'h5000 + 32'(4 * i)));
      start_job(1'b1, 32'h5000, 16'd4);
      run_until_done(300, ok);
      checks++;
      if (ok !== 1'b1 || obs_rd.size() !== 4) $display("FAIL err_complete got ok=%b words=%0d exp 1/4", ok, obs_rd.size());
      else passed++;
      while (exp_rd.size() > 0) begin
         a = obs_rd.size() > 0 ? obs_rd.pop_front() : 32'hx;
         checks++;
         if (a !== exp_rd[0]) $display("FAIL err_data got %h exp %h", a, exp_rd[0]);
         else passed++;
         void'(exp_rd.pop_front());
      end
      checks++;
      if (bp_bad !== 0) $display("FAIL rsp_backpressure got %0d violations exp 0", bp_bad);
      else passed++;
      step(); step();
      checks++;
      if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err);
      else passed++;
      start_job(1'b1, 32'h6000, 16'd0);
      checks++;
      if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err);
      else passed++;
      run_until_done(10, ok);
   endtask

   task automatic test_async_reset();
      clear();
      hold_rsp = 1;
      start_job(1'b1, 32'h7000, 16'd8);
      repeat (3) step();
      test_reset();
      repeat (5) step();
      checks++;
      if (done_cnt !== 0 || obs_addr.size() !== 0 || busy !== 1'b0)
         $display("FAIL abort got done=%0d cmds=%0d busy=%b exp 0/0/0", done_cnt, obs_addr.size(), busy);
      else passed++;
   endtask

   task automatic test_align();
      bit ok;
      clear();
      start_job(1'b1, 32'h1002, 16'd1);
`ifdef ICB_MST_ALIGN_CHK_EN
      step();
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || obs_addr.size() !== 0)
         $display("FAIL align_reject got done=%b err=%b cmds=%0d exp 1/1/0", done, err, obs_addr.size());
      else passed++;
`else
      run_until_done(20, ok);
      checks++;
      if (ok !== 1'b1 || obs_addr.size() != 1 || obs_addr[0] !== 32'h1000)
         $display("FAIL align_force got ok=%b cmds=%0d addr=%h exp 1/1/00001000", ok, obs_addr.size(),
                  obs_addr.size() > 0 ? obs_addr[0] : 32'hx);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_outstanding();
      test_len0_wrap();
      test_err();
      test_async_reset();
      test_align();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
